// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: synchronised and filtered pin sampling, 11-bit frame checking,
// E0/F0 prefix decoding, typematic repeat suppression and a first-word-fall-through event FIFO.
module ps2_key_fifo #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned DROP_REPEAT    = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     PS2CLK,
  input  logic                     PS2Data,
  output logic [7:0]               KeyCode,
  output logic                     KeyExt,
  output logic                     KeyBrk,
  output logic                     KeyValid,
  input  logic                     KeyReady,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     ParityErr,
  output logic                     FrameErr,
  output logic                     Overflow,
  input  logic                     ClrOvf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] WdMax   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] FullLvl = LW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_s, dat_s;
  logic                   filt_q, filt_dly_q, strobe;
  logic [FW-1:0]          fcnt_q;

  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d, stop_q, stop_d, check_q, check_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          timeout, par_ok;
  logic          perr_q, perr_d, ferr_q, ferr_d, bval_q, bval_d;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic [8:0]    lm_q, lm_d;
  logic          lm_valid_q, lm_valid_d;
  logic          ev_valid, is_repeat, push_req;
  logic [9:0]    ev;

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, full, pop, do_push;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];
  assign strobe = filt_dly_q & ~filt_q;

  // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2CLK};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2Data};
      filt_dly_q <= filt_q;
      if (clk_s != filt_q) begin
        if (fcnt_q == FiltMax) begin
          filt_q <= clk_s;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    stop_d   = stop_q;
    check_d  = 1'b0;
    timeout  = 1'b0;
    wd_d     = (state_q == StIdle || strobe) ? '0 : wd_q + TW'(1);
    if (state_q != StIdle && wd_q == WdMax) begin
      state_d = StIdle;
      timeout = 1'b1;
      wd_d    = '0;
    end else if (strobe) begin
      case (state_q)
        StIdle: begin
          if (!dat_s) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s;
          state_d = StStop;
        end
        StStop: begin
          stop_d  = dat_s;
          check_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame verdict one cycle after the stop strobe; odd parity means the XOR must be 1.
  always_comb begin
    par_ok = ^{shift_q, par_q};
    perr_d = check_q & stop_q & ~par_ok;
    ferr_d = (check_q & ~stop_q) | timeout;
    bval_d = check_q & stop_q & par_ok;
  end

  always_comb begin
    ev         = {ext_q, brk_q, shift_q};
    ev_valid   = bval_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);
    is_repeat  = (DROP_REPEAT != 0) && !brk_q && lm_valid_q && (lm_q == {ext_q, shift_q});
    push_req   = ev_valid && !is_repeat;
    ext_d      = ext_q;
    brk_d      = brk_q;
    lm_d       = lm_q;
    lm_valid_d = lm_valid_q;
    if (perr_q || ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (bval_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (push_req && !brk_q) begin
      lm_d       = {ext_q, shift_q};
      lm_valid_d = 1'b1;
    end else if (ev_valid && brk_q && lm_valid_q && (lm_q == {ext_q, shift_q})) begin
      lm_valid_d = 1'b0;
    end
  end

  // A pop frees the head slot in the same edge, so a full FIFO can still accept a push.
  always_comb begin
    full     = (count_q == FullLvl);
    pop      = KeyValid && KeyReady;
    do_push  = push_req && (!full || pop);
    wr_ptr_d = wr_ptr_q + (do_push ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
    count_d  = count_q + LW'(do_push) - LW'(pop);
    ovf_d    = ovf_q;
    if (ClrOvf) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      check_q    <= 1'b0;
      wd_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      bval_q     <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      lm_q       <= '0;
      lm_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      check_q    <= check_d;
      wd_q       <= wd_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      bval_q     <= bval_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      lm_q       <= lm_d;
      lm_valid_q <= lm_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= ev;
    end
  end

  assign {KeyExt, KeyBrk, KeyCode} = mem_q[rd_ptr_q];
  assign KeyValid  = (count_q != '0);
  assign Level     = count_q;
  assign ParityErr = perr_q;
  assign FrameErr  = ferr_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo: drives PS/2 frames, keeps a keystroke-level event model and
// checks FIFO state, popped events and error pulses against it.
module tb_ps2_key_fifo;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned HALF    = 20;

  logic       CLK = 1'b0, RST_N = 1'b0, PS2CLK = 1'b1, PS2Data = 1'b1;
  logic       KeyReady = 1'b0, ClrOvf = 1'b0;
  logic [7:0] KeyCode;
  logic       KeyExt, KeyBrk, KeyValid, ParityErr, FrameErr, Overflow;
  logic [3:0] Level;

  ps2_key_fifo #(
    .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .DEPTH(DEPTH), .DROP_REPEAT(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2CLK(PS2CLK), .PS2Data(PS2Data),
    .KeyCode(KeyCode), .KeyExt(KeyExt), .KeyBrk(KeyBrk), .KeyValid(KeyValid),
    .KeyReady(KeyReady), .Level(Level), .ParityErr(ParityErr), .FrameErr(FrameErr),
    .Overflow(Overflow), .ClrOvf(ClrOvf)
  );

  always #5 CLK = ~CLK;

  // Model: pending events, prefix flags, last held make key, overflow flag.
  logic [9:0] mq[$];
  logic [9:0] log_q[$];
  logic       m_ext = 1'b0, m_brk = 1'b0, m_lm_valid = 1'b0, m_ovf = 1'b0;
  logic [8:0] m_lm = '0;
  int         exp_perr = 0, exp_ferr = 0, perr_seen = 0, ferr_seen = 0;
  int         checks = 0, errors = 0;
  bit         settled = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic gap(input int n);
    settled = 1'b1;
    cyc(n);
    settled = 1'b0;
  endtask

  task automatic model_error();
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    model_error();
    m_lm_valid = 1'b0;
    m_lm       = '0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic same;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      same = m_lm_valid && (m_lm == {m_ext, b});
      if (m_brk) begin
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back({m_ext, m_brk, b});
        if (same) m_lm_valid = 1'b0;
      end else if (!same) begin
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back({m_ext, m_brk, b});
        m_lm       = {m_ext, b};
        m_lm_valid = 1'b1;
      end
      model_error();
    end
  endtask

  // nbits < 11 sends only a truncated frame (start plus nbits-1 data bits).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2Data = bits[i];
      cyc(HALF / 2);
      PS2CLK = 1'b0;
      if (i == 10) begin
        if (bad_stop) begin
          exp_ferr++;
          model_error();
        end else if (bad_par) begin
          exp_perr++;
          model_error();
        end else begin
          model_byte(b);
        end
      end
      cyc(HALF);
      PS2CLK = 1'b1;
      cyc(HALF / 2);
    end
    PS2Data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [9:0] exp);
    if (idx < log_q.size()) chk(name, log_q[idx], exp);
  endtask

  always @(negedge CLK) begin
    if (ParityErr) perr_seen++;
    if (FrameErr) ferr_seen++;
  end

  // Single compare process: full state check in quiet windows, content check on every pop.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (settled) begin
        chk("level", Level, mq.size());
        chk("key_valid", KeyValid, 1'(mq.size() != 0));
        chk("overflow", Overflow, m_ovf);
        chk("parity_pulses", perr_seen, exp_perr);
        chk("frame_pulses", ferr_seen, exp_ferr);
        if (mq.size() != 0) chk("head", {KeyExt, KeyBrk, KeyCode}, mq[0]);
      end
      if (KeyValid && KeyReady) begin
        if (mq.size() == 0) begin
          chk("pop_valid", KeyValid, 1'b0);
        end else begin
          chk("pop_data", {KeyExt, KeyBrk, KeyCode}, mq[0]);
          log_q.push_back({KeyExt, KeyBrk, KeyCode});
          void'(mq.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    cyc(3);
    chk("reset_outputs", {KeyCode, KeyExt, KeyBrk, KeyValid, Level, ParityErr, FrameErr,
        Overflow}, 0);
    RST_N = 1'b1;
    gap(5);

    // Press and release 'A'.
    KeyReady = 1'b1;
    log_q.delete();
    send(8'h1C);
    gap(4);
    send(8'hF0);
    send(8'h1C);
    gap(10);
    chk("a_count", log_q.size(), 2);
    chk_log("a_make", 0, {2'b00, 8'h1C});
    chk_log("a_break", 1, {2'b01, 8'h1C});
    chk("a_level", Level, 0);

    // Right arrow make and break.
    log_q.delete();
    send(8'hE0); send(8'h74); gap(3);
    send(8'hE0); send(8'hF0); send(8'h74);
    gap(10);
    chk("arrow_count", log_q.size(), 2);
    chk_log("arrow_make", 0, {2'b10, 8'h74});
    chk_log("arrow_break", 1, {2'b11, 8'h74});

    // Parity error, then a break that must not inherit stale prefixes.
    log_q.delete();
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    gap(10);
    chk("perr_pulses", perr_seen, 1);
    chk("perr_no_event", log_q.size(), 0);
    send(8'hF0); send(8'h1C);
    gap(10);
    chk("perr_follow", log_q.size(), 1);
    chk_log("perr_follow_ev", 0, {2'b01, 8'h1C});

    // Bad stop bit.
    send_frame(8'h33, 1'b0, 1'b1, 11);
    gap(10);
    chk("stop_err_pulses", ferr_seen, 1);

    // Timeout after E0 and a truncated frame.
    log_q.delete();
    send(8'hE0);
    send_frame(8'h55, 1'b0, 1'b0, 4);
    model_error();
    exp_ferr++;
    cyc(TIMEOUT + 50);
    gap(5);
    chk("timeout_pulses", ferr_seen, 2);
    send(8'h29);
    gap(10);
    chk("timeout_follow", log_q.size(), 1);
    chk_log("timeout_follow_ev", 0, {2'b00, 8'h29});

    // Typematic repeat suppression.
    KeyReady = 1'b0;
    log_q.delete();
    send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D); send(8'h1D);
    gap(10);
    chk("repeat_level", Level, 3);
    KeyReady = 1'b1;
    gap(10);
    KeyReady = 1'b0;
    chk("repeat_count", log_q.size(), 3);
    chk_log("repeat_ev0", 0, {2'b00, 8'h1D});
    chk_log("repeat_ev1", 1, {2'b01, 8'h1D});
    chk_log("repeat_ev2", 2, {2'b00, 8'h1D});

    // Overflow with nine distinct makes into an eight-entry FIFO.
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    gap(10);
    chk("ovf_level", Level, 8);
    chk("ovf_flag", Overflow, 1);
    chk("ovf_head", KeyCode, 8'h15);
    log_q.delete();
    KeyReady = 1'b1;
    gap(12);
    KeyReady = 1'b0;
    chk("ovf_drain_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) chk_log("ovf_drain_ev", i, {2'b00, 8'h15 + 8'(i)});
    ClrOvf = 1'b1;
    cyc(1);
    ClrOvf = 1'b0;
    m_ovf  = 1'b0;
    gap(3);
    chk("ovf_cleared", Overflow, 0);

    // Asynchronous reset mid-frame with a pending prefix and a non-empty FIFO.
    send(8'h2A);
    send(8'hE0);
    gap(3);
    chk("pre_reset_level", Level, 1);
    PS2Data = 1'b0;
    cyc(5);
    PS2CLK = 1'b0;
    cyc(10);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_reset_outputs", {KeyCode, KeyExt, KeyBrk, KeyValid, Level, ParityErr,
        FrameErr, Overflow}, 0);
    PS2CLK  = 1'b1;
    PS2Data = 1'b1;
    model_reset();
    cyc(5);
    RST_N = 1'b1;
    gap(20);
    log_q.delete();
    KeyReady = 1'b1;
    send(8'h6B);
    gap(10);
    chk("post_reset_count", log_q.size(), 1);
    chk_log("post_reset_ev", 0, {2'b00, 8'h6B});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
Next-generation PS/2 keyboard receiver. It runs entirely in the system clock domain, oversampling and filtering PS2CLK and PS2Data. It validates full 11-bit frames (start, 8 data LSB-first, odd parity, stop), assembles E0/F0 prefixes into make/break events, and buffers events in a parametrised FIFO with a valid/ready handshake toward game logic.

Parameters:
SYNC_STAGES, 2, synchroniser flops on PS2CLK and PS2Data (min 2)
FILTER_LEN, 8, consecutive identical samples before the filtered PS2CLK level may change (min 1)
TIMEOUT_CYCLES, 100000, CLK cycles without a falling edge before an in-progress frame is aborted
DEPTH, 8, FIFO entries, power of 2, min 2
DROP_REPEAT, 1, 1 = suppress typematic repeats of the last held make code

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
PS2CLK  in  1  raw PS/2 clock from the pin
PS2Data  in  1  raw PS/2 data from the pin
KeyCode  out  8  scan code at the FIFO head
KeyExt  out  1  head event had an E0 prefix
KeyBrk  out  1  head event is a break (F0 prefix)
KeyValid  out  1  FIFO not empty
KeyReady  in  1  consumer pops the head when KeyValid and KeyReady are both high
Level  out  log2(DEPTH)+1  FIFO occupancy
ParityErr  out  1  one-cycle pulse on a parity failure
FrameErr  out  1  one-cycle pulse on a bad stop bit or a timeout
Overflow  out  1  sticky; set when an event is dropped because the FIFO is full
ClrOvf  in  1  synchronous clear of Overflow

Behaviour:
- Reset (async assert, sync release): all outputs 0, KeyCode=8'h00, FIFO empty, FSM IDLE. Filtered clock resets to 1, data synchroniser resets to 1. Prefix flags, last-make register and its valid bit are cleared.
- Input path: SYNC_STAGES flops per input, then a glitch filter on the clock. Strobe = one-CLK pulse on a 1->0 transition of the filtered clock. Data is sampled from the synchronised PS2Data in the strobe cycle.
- Frame FSM, advancing only on strobe:
  - IDLE: sample 0 -> DATA with bitcnt=0. Sample 1 -> stay in IDLE, no error.
  - DATA: shift right, data enters the MSB (LSB-first assembly). bitcnt 7 -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: evaluate the frame -> IDLE.
- Frame check in the cycle after the STOP strobe (S+1):
  - Stop bit 0 -> FrameErr pulse.
  - Otherwise, if XOR(data, parity) is 0 -> ParityErr pulse.
  - Otherwise -> internal byte_valid pulse.
  - At most one of the three per frame.
- Timeout: the watchdog counter clears on every strobe and while IDLE. If it reaches TIMEOUT_CYCLES-1 outside IDLE -> FSM to IDLE, FrameErr pulse, partial byte discarded.
- Decoder, at S+2 on byte_valid:
  - 8'hE0 -> set ext flag, no event.
  - 8'hF0 -> set brk flag, no event.
  - Any other byte -> event {ext, brk, byte}, both flags cleared.
  - A ParityErr or FrameErr also clears both flags.
- Repeat filter (DROP_REPEAT=1):
  - A make event equal to last-make {ext, code} while last-make is valid is not pushed.
  - A make event that is pushed updates last-make.
  - A break event matching last-make clears the valid bit.
  - DROP_REPEAT=0 pushes every event.
- FIFO: first-word-fall-through; KeyValid, KeyCode, KeyExt and KeyBrk are driven from registered state.
  - An event pushed at edge S+2 is visible in the cycle after S+2.
  - End-to-end: pin falling edge to KeyValid is SYNC_STAGES+FILTER_LEN+3 CLK cycles, +/-1 for pin-to-clock alignment.
  - Pop when KeyValid && KeyReady; the head advances next edge. Pointers wrap modulo DEPTH.
  - Push while full without a pop in the same cycle -> event dropped, Overflow <= 1, FIFO contents unchanged.
  - Push and pop in the same cycle while full -> both happen, no drop, Level unchanged.
  - Push and pop in the same cycle while empty -> push only (KeyValid was 0).
  - Overflow is cleared by ClrOvf. A set and a clear in the same cycle -> set wins.
- Reset mid-frame or mid-sequence: everything returns to the reset state. The next byte is decoded without stale prefixes.

Test Plan:
- Press 'A' (1C) then release (F0 1C), KeyReady=1 -> two events: {Ext0,Brk0,1C} then {Ext0,Brk1,1C}; Level returns to 0; no error pulses.
- Right arrow (E0 74, E0 F0 74) -> {1,0,74} then {1,1,74}; prefix bytes never appear in the FIFO.
- Frame 1C with parity bit inverted -> exactly one ParityErr pulse, no event. Following frame F0 1C -> {0,1,1C}, proving the flags were cleared.
- Send E0 then 3 data bits, stall for TIMEOUT_CYCLES -> one FrameErr pulse, FSM back to IDLE. Next frame 29 decodes as {0,0,29}, not extended.
- DROP_REPEAT=1, send 1D 1D 1D F0 1D 1D -> FIFO holds {0,0,1D}, {0,1,1D}, {0,0,1D} only.
- DEPTH=8, KeyReady=0, send 9 make codes 15..1D (distinct, no repeats):
  - Level=8, Overflow=1 after the 9th, KeyCode=15.
  - Popping 8 times yields 15..1C in order.
  - ClrOvf clears Overflow.
  - Async RST_N low mid-frame -> all outputs 0 immediately.
